// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array output drain: collector state encoding, default result
// width and the chain index mapping used when serialising each row.
package pe_array_pkg;

    localparam int unsigned OutputWidthDef = 24;

    // Position of a row's chain inside its pair of output words.
    localparam int unsigned ChainEven = 0;
    localparam int unsigned ChainOdd  = 1;

    typedef logic [2:0] coll_state_t;

    localparam coll_state_t StIdle    = 3'd0;
    localparam coll_state_t StRead    = 3'd1;
    localparam coll_state_t StCapture = 3'd2;
    localparam coll_state_t StSend    = 3'd3;
    localparam coll_state_t StDone    = 3'd4;

endpackage

// File: rtl/out_collector_serializer.sv
// Capture buffer plus word-by-word valid/ready serialiser for one drain beat.
// Optional feature: OUT_COLLECTOR_RELU_EN clamps negative captured words to zero.
module out_collector_serializer
    import pe_array_pkg::*;
#(
    parameter int unsigned NumPeRow    = 1,
    parameter int unsigned OutputWidth = OutputWidthDef
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                capture_i,
    input  logic                                send_i,
    input  logic                                last_beat_i,
    input  logic [NumPeRow-1:0][OutputWidth-1:0] even_i,
    input  logic [NumPeRow-1:0][OutputWidth-1:0] odd_i,
    input  logic                                ob_ready_i,
    output logic                                ob_valid_o,
    output logic [OutputWidth-1:0]              ob_data_o,
    output logic                                ob_last_o,
    output logic                                xfer_o,
    output logic                                beat_end_o
);

    localparam int unsigned NumWords = 2 * NumPeRow;
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    logic [NumWords-1:0][OutputWidth-1:0] buf_q, buf_d;
    logic [NumWords-1:0][OutputWidth-1:0] cap_words;
    logic [IdxW-1:0]                      idx_q, idx_d;
    logic                                 at_last_word;

    function automatic logic [OutputWidth-1:0] cond_word(input logic [OutputWidth-1:0] w);
`ifdef OUT_COLLECTOR_RELU_EN
        return w[OutputWidth-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    for (genvar r = 0; r < NumPeRow; r++) begin : g_cap
        assign cap_words[2*r+ChainEven] = cond_word(even_i[r]);
        assign cap_words[2*r+ChainOdd]  = cond_word(odd_i[r]);
    end

    assign at_last_word = (idx_q == LastIdx);
    assign ob_valid_o   = send_i;
    assign xfer_o       = send_i & ob_ready_i;
    assign beat_end_o   = xfer_o & at_last_word;
    assign ob_data_o    = buf_q[idx_q];
    assign ob_last_o    = send_i & last_beat_i & at_last_word;

    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (capture_i) begin
            buf_d = cap_words;
        end
        if (clear_i) begin
            idx_d = '0;
        end else if (xfer_o) begin
            idx_d = at_last_word ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/pe_array_out_collector.sv
// Drains the rightmost even/odd PE chains of every row into the output buffer, a programmable
// number of beats per job. Optional feature: OUT_COLLECTOR_RELU_EN (negative words become 0).
module pe_array_out_collector
    import pe_array_pkg::*;
#(
    parameter int unsigned num_pe_row     = 1,
    parameter int unsigned output_width   = OutputWidthDef,
    parameter int unsigned addr_width     = 10,
    parameter int unsigned beat_cnt_width = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [beat_cnt_width-1:0]             n_beats,
    input  logic [addr_width-1:0]                 base_addr,
    input  logic [num_pe_row-1:0][output_width-1:0] even_col_in,
    input  logic [num_pe_row-1:0][output_width-1:0] odd_col_in,
    input  logic [2*num_pe_row-1:0]               chain_empty,
    output logic [2*num_pe_row-1:0]               drain_read,
    output logic                                  ob_valid,
    input  logic                                  ob_ready,
    output logic [output_width-1:0]               ob_data,
    output logic [addr_width-1:0]                 ob_addr,
    output logic                                  ob_last,
    output logic                                  busy,
    output logic                                  done
);

    coll_state_t               state_q, state_d;
    logic [beat_cnt_width-1:0] n_beats_q, n_beats_d;
    logic [beat_cnt_width-1:0] beat_cnt_q, beat_cnt_d;
    logic [beat_cnt_width-1:0] beat_cnt_inc;
    logic [addr_width-1:0]     addr_q, addr_d;

    logic chains_ready;
    logic rd_fire;
    logic clear_idx;
    logic capture;
    logic send;
    logic last_beat;
    logic xfer;
    logic beat_end;

    assign chains_ready = ~|chain_empty;
    assign rd_fire      = (state_q == StRead) && chains_ready;
    assign send         = (state_q == StSend);
    assign beat_cnt_inc = beat_cnt_q + 1'b1;
    assign last_beat    = (beat_cnt_inc == n_beats_q);

    // Every chain is popped together so rows stay aligned beat for beat.
    assign drain_read = {(2*num_pe_row){rd_fire}};
    assign busy       = (state_q == StRead) || (state_q == StCapture) || send;
    assign done       = (state_q == StDone);
    assign ob_addr    = addr_q;

    always_comb begin
        state_d    = state_q;
        n_beats_d  = n_beats_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        clear_idx  = 1'b0;
        capture    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    n_beats_d  = n_beats;
                    beat_cnt_d = '0;
                    addr_d     = base_addr;
                    clear_idx  = 1'b1;
                    state_d    = (n_beats == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (chains_ready) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                capture = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (xfer) begin
                    addr_d = addr_q + 1'b1;
                end
                if (beat_end) begin
                    beat_cnt_d = beat_cnt_inc;
                    state_d    = last_beat ? StDone : StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            n_beats_q  <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_beats_q  <= n_beats_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
        end
    end

    out_collector_serializer #(
        .NumPeRow    (num_pe_row),
        .OutputWidth (output_width)
    ) u_serializer (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear_idx),
        .capture_i   (capture),
        .send_i      (send),
        .last_beat_i (last_beat),
        .even_i      (even_col_in),
        .odd_i       (odd_col_in),
        .ob_ready_i  (ob_ready),
        .ob_valid_o  (ob_valid),
        .ob_data_o   (ob_data),
        .ob_last_o   (ob_last),
        .xfer_o      (xfer),
        .beat_end_o  (beat_end)
    );

endmodule

// File: tb/tb_pe_array_out_collector.sv
// Randomised bench for pe_array_out_collector with a queue-based reference model of the
// word stream, plus literal checks of the directed scenarios.
module tb_pe_array_out_collector;

    localparam int NR = 2;
    localparam int OW = 24;
    localparam int AW = 10;
    localparam int BW = 16;
    localparam int NC = 2 * NR;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [BW-1:0]          n_beats = '0;
    logic [AW-1:0]          base_addr = '0;
    logic [NR-1:0][OW-1:0]  even_col_in = '0;
    logic [NR-1:0][OW-1:0]  odd_col_in = '0;
    logic [NC-1:0]          chain_empty = '0;
    logic [NC-1:0]          drain_read;
    logic                   ob_valid;
    logic                   ob_ready = 1'b0;
    logic [OW-1:0]          ob_data;
    logic [AW-1:0]          ob_addr;
    logic                   ob_last;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    pe_array_out_collector #(
        .num_pe_row     (NR),
        .output_width   (OW),
        .addr_width     (AW),
        .beat_cnt_width (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_beats     (n_beats),
        .base_addr   (base_addr),
        .even_col_in (even_col_in),
        .odd_col_in  (odd_col_in),
        .chain_empty (chain_empty),
        .drain_read  (drain_read),
        .ob_valid    (ob_valid),
        .ob_ready    (ob_ready),
        .ob_data     (ob_data),
        .ob_addr     (ob_addr),
        .ob_last     (ob_last),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic [OW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [OW-1:0] preset[$];
    logic [OW-1:0] log_d[$];
    logic [AW-1:0] log_a[$];
    logic          log_l[$];
    logic [OW-1:0] beat_w[NC];

    int checks = 0;
    int failures = 0;

    bit            job_active = 0;
    bit            job_done_flag = 0;
    int            job_cyc = 0;
    int            beats_left = 0;
    int            drains = 0;
    int            n_job = 0;
    int            done_cyc = -1;
    logic [AW-1:0] exp_addr = '0;
    bit            pend_data = 0;
    bit            garb = 0;
    int            ready_mode = 0;
    bit            empty_mode = 0;
    bit            stall_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [OW-1:0] model_word(input logic [OW-1:0] w);
`ifdef OUT_COLLECTOR_RELU_EN
        return ($signed(w) < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Reference model and comparisons, evaluated at the falling edge.
    task automatic monitor();
        exp_t e;
        logic [OW-1:0] w;
        if (!rst_n) begin
            exp_q.delete();
            job_active = 0;
            beats_left = 0;
            pend_data  = 0;
            return;
        end
        if (job_active) job_cyc++;
        chk("busy", 32'(busy), 32'(job_active && job_cyc >= 1 && n_job != 0 && !done));
        if (ob_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got data %0h addr %0h, no word expected",
                         ob_data, ob_addr);
            end else begin
                e = exp_q[0];
                chk("ob_data", 32'(ob_data), 32'(e.d));
                chk("ob_addr", 32'(ob_addr), 32'(e.a));
                chk("ob_last", 32'(ob_last), 32'(e.l));
                if (ob_ready) begin
                    log_d.push_back(ob_data);
                    log_a.push_back(ob_addr);
                    log_l.push_back(ob_last);
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("ob_last_idle", 32'(ob_last), 32'd0);
        end
        chk("drain_read_gate",
            32'(drain_read != '0 && (drain_read != '1 || chain_empty != '0)), 32'd0);
        if (drain_read == '1 && chain_empty == '0) begin
            drains++;
            if (beats_left <= 0) begin
                checks++;
                failures++;
                $display("FAIL extra_drain_read: got pulse %0d, expected at most %0d",
                         drains, n_job);
            end else begin
                for (int i = 0; i < NC; i++) begin
                    w = (preset.size() != 0) ? preset.pop_front() : OW'($urandom);
                    beat_w[i] = w;
                    e.d = model_word(w);
                    e.a = exp_addr;
                    e.l = (beats_left == 1 && i == NC - 1);
                    exp_q.push_back(e);
                    exp_addr = exp_addr + 1'b1;
                end
                beats_left--;
                pend_data = 1;
            end
        end
        if (done) begin
            if (!job_active) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected 0 (no job)");
            end else begin
                chk("done_drain_count", 32'(drains), 32'(n_job));
                chk("done_words_left", 32'(exp_q.size()), 32'd0);
                done_cyc      = job_cyc;
                job_active    = 0;
                job_done_flag = 1;
            end
        end
        if (start && !busy && !done) begin
            job_active = 1;
            job_cyc    = 0;
            n_job      = int'(n_beats);
            beats_left = int'(n_beats);
            exp_addr   = base_addr;
            drains     = 0;
            done_cyc   = -1;
        end
    endtask

    // Input drivers for the next cycle, applied just after the rising edge.
    task automatic drive();
        case (ready_mode)
            0:       ob_ready = 1'b1;
            1:       ob_ready = ~ob_ready;
            default: ob_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (stall_en && job_active && job_cyc + 1 >= 1 && job_cyc + 1 <= 5)
            chain_empty = 4'b1000;
        else if (empty_mode)
            chain_empty = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
        else
            chain_empty = '0;
        if (pend_data) begin
            even_col_in = {beat_w[2], beat_w[0]};
            odd_col_in  = {beat_w[3], beat_w[1]};
            pend_data   = 0;
            garb        = 1;
        end else if (garb) begin
            even_col_in = {OW'($urandom), OW'($urandom)};
            odd_col_in  = {OW'($urandom), OW'($urandom)};
            garb        = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_job(input int n, input logic [AW-1:0] base, input int extra_at,
                           input int budget);
        int k;
        log_d.delete();
        log_a.delete();
        log_l.delete();
        job_done_flag = 0;
        n_beats   = BW'(n);
        base_addr = base;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        n_beats   = BW'($urandom);
        base_addr = AW'($urandom);
        k = 1;
        while (!job_done_flag && k < budget) begin
            start = (k == extra_at);
            cycle();
            k++;
        end
        start = 1'b0;
        if (!job_done_flag) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: got no done within %0d cycles, expected done", budget);
        end
        repeat (3) cycle();
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drain_read", 32'(drain_read), 32'd0);
        chk("rst_ob_valid", 32'(ob_valid), 32'd0);
        chk("rst_ob_data", 32'(ob_data), 32'd0);
        chk("rst_ob_addr", 32'(ob_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Single beat, known data; a start coincident with DONE must be ignored.
        ready_mode = 0;
        preset = '{24'd5, 24'd6, 24'd7, 24'd8};
        run_job(1, 10'h010, 7, 100);
        chk("t1_done_cycle", 32'(done_cyc), 32'd7);
        chk("t1_word_count", 32'(log_d.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", 32'(log_d[i]), 32'(5 + i));
            chk("t1_addr", 32'(log_a[i]), 32'(16 + i));
            chk("t1_last", 32'(log_l[i]), 32'(i == 3));
        end

        // Back-pressure toggling every cycle.
        ready_mode = 1;
        run_job(3, 10'h100, 0, 200);
        chk("t2_drain_count", 32'(drains), 32'd3);
        chk("t2_word_count", 32'(log_d.size()), 32'd12);

        // Chain 3 empty for five READ cycles.
        ready_mode = 0;
        stall_en   = 1;
        run_job(1, 10'h020, 0, 100);
        stall_en   = 0;
        chk("t3_done_cycle", 32'(done_cyc), 32'd12);
        chk("t3_word_count", 32'(log_d.size()), 32'd4);

        // Address wrap.
        run_job(1, 10'h3FE, 0, 100);
        chk("t4_addr0", 32'(log_a[0]), 32'h3FE);
        chk("t4_addr1", 32'(log_a[1]), 32'h3FF);
        chk("t4_addr2", 32'(log_a[2]), 32'h000);
        chk("t4_addr3", 32'(log_a[3]), 32'h001);

        // Zero beats.
        run_job(0, 10'h055, 0, 50);
        chk("t5_done_cycle", 32'(done_cyc), 32'd1);
        chk("t5_drain_count", 32'(drains), 32'd0);
        chk("t5_word_count", 32'(log_d.size()), 32'd0);

        // Negative word handling.
        preset = '{24'hFFFFFD, 24'd4, 24'd0, 24'd0};
        run_job(1, 10'h000, 0, 100);
`ifdef OUT_COLLECTOR_RELU_EN
        chk("t6_neg_word", 32'(log_d[0]), 32'h0);
`else
        chk("t6_neg_word", 32'(log_d[0]), 32'hFFFFFD);
`endif
        chk("t6_pos_word", 32'(log_d[1]), 32'd4);

        // Reset during SEND of beat 2, then a complete job.
        ready_mode    = 2;
        job_done_flag = 0;
        n_beats       = BW'(3);
        base_addr     = AW'($urandom);
        start         = 1'b1;
        cycle();
        start = 1'b0;
        k = 0;
        while (!(drains == 2 && ob_valid) && k < 200) begin
            cycle();
            k++;
        end
        chk("t7_reached_beat2", 32'(drains == 2 && ob_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_drain_read", 32'(drain_read), 32'd0);
        chk("t7_ob_valid", 32'(ob_valid), 32'd0);
        chk("t7_ob_data", 32'(ob_data), 32'd0);
        chk("t7_ob_addr", 32'(ob_addr), 32'd0);
        chk("t7_ob_last", 32'(ob_last), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        run_job(2, AW'($urandom), 0, 300);
        chk("t7_post_reset_words", 32'(log_d.size()), 32'd8);

        // Randomised jobs with back-pressure, chain stalls and stray starts while busy.
        empty_mode = 1;
        for (int j = 0; j < 20; j++) begin
            k = $urandom_range(1, 4);
            run_job(k, AW'($urandom), $urandom_range(2, 8), 600);
            chk("rand_word_count", 32'(log_d.size()), 32'(k * NC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
